// File: rtl/inst_fetch_queue.sv
// Multi-lane instruction queue between fetch and the decode lanes.
// Optional delay-slot retention on flush is enabled by defining IQ_DELAY_SLOT_EN.
module inst_fetch_queue #(
  parameter int unsigned LANES = 2,
  parameter int unsigned DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [LANES-1:0]               in_valid,
  input  logic [32*LANES-1:0]            in_pc,
  input  logic [32*LANES-1:0]            in_inst,
  input  logic [2*LANES-1:0]             in_exc,
  output logic                           in_ready,
  output logic [LANES-1:0]               out_valid,
  output logic [32*LANES-1:0]            out_pc,
  output logic [32*LANES-1:0]            out_inst,
  output logic [2*LANES-1:0]             out_exc,
  input  logic [$clog2(LANES+1)-1:0]     out_take,
  input  logic                           flush,
  input  logic                           flush_keep,
  output logic [$clog2(DEPTH):0]         count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [1:0]  exc;
  } entry_t;

  entry_t                mem_q [DEPTH];
  entry_t                mem_d [DEPTH];
  logic [PW-1:0]         head_q, tail_q, head_d, tail_d, count_d;
  logic [PW-1:0]         n_push, n_pop, n_avail, take_w;
  logic [LANES-1:0]      out_valid_d;
  logic [32*LANES-1:0]   out_pc_d, out_inst_d;
  logic [2*LANES-1:0]    out_exc_d;
  entry_t                rd_e;

`ifndef IQ_DELAY_SLOT_EN
  logic unused_flush_keep;
  assign unused_flush_keep = flush_keep;
`endif

  // Next-state: writes, pointer moves, flush handling, and next head view.
  always_comb begin
    mem_d       = mem_q;
    n_push      = '0;
    out_valid_d = '0;
    out_pc_d    = '0;
    out_inst_d  = '0;
    out_exc_d   = '0;
    rd_e        = '0;

    for (int unsigned i = 0; i < LANES; i++) begin
      if (in_ready && in_valid[i]) begin
        mem_d[AW'(tail_q + PW'(i))] = '{pc:   in_pc[32*i +: 32],
                                        inst: in_inst[32*i +: 32],
                                        exc:  in_exc[2*i +: 2]};
        n_push = n_push + PW'(1);
      end
    end

    // Pop is clamped to what is actually presented on the output lanes.
    n_avail = (count > PW'(LANES)) ? PW'(LANES) : count;
    take_w  = PW'(out_take);
    n_pop   = (take_w < n_avail) ? take_w : n_avail;

    head_d = head_q + n_pop;
    tail_d = tail_q + n_push;

    if (flush) begin
`ifdef IQ_DELAY_SLOT_EN
      if (flush_keep && (count != n_pop)) begin
        tail_d = head_d + PW'(1);
      end else if (flush_keep && (n_push != '0)) begin
        head_d = tail_q;
        tail_d = tail_q + PW'(1);
      end else begin
        head_d = tail_q;
        tail_d = tail_q;
      end
`else
      head_d = tail_q;
      tail_d = tail_q;
`endif
    end

    count_d = tail_d - head_d;

    for (int unsigned i = 0; i < LANES; i++) begin
      if (count_d > PW'(i)) begin
        rd_e                   = mem_d[AW'(head_d + PW'(i))];
        out_valid_d[i]         = 1'b1;
        out_pc_d[32*i +: 32]   = rd_e.pc;
        out_inst_d[32*i +: 32] = rd_e.inst;
        out_exc_d[2*i +: 2]    = rd_e.exc;
      end
    end
  end

  // Storage array carries no reset; only entries below count are ever presented.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      count     <= '0;
      in_ready  <= 1'b1;
      out_valid <= '0;
      out_pc    <= '0;
      out_inst  <= '0;
      out_exc   <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count     <= count_d;
      in_ready  <= (PW'(DEPTH) - count_d) >= PW'(LANES);
      out_valid <= out_valid_d;
      out_pc    <= out_pc_d;
      out_inst  <= out_inst_d;
      out_exc   <= out_exc_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed vector table, async reset, wrap stream, random vs queue model.
module tb_inst_fetch_queue;

  localparam int unsigned LANES = 2;
  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  in_valid;
  logic [63:0] in_pc, in_inst;
  logic [3:0]  in_exc;
  logic        in_ready;
  logic [1:0]  out_valid;
  logic [63:0] out_pc, out_inst;
  logic [3:0]  out_exc;
  logic [1:0]  out_take;
  logic        flush, flush_keep;
  logic [3:0]  count;

  always #5 clk = ~clk;

  inst_fetch_queue #(.LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
    .in_exc(in_exc), .in_ready(in_ready), .out_valid(out_valid), .out_pc(out_pc),
    .out_inst(out_inst), .out_exc(out_exc), .out_take(out_take), .flush(flush),
    .flush_keep(flush_keep), .count(count)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [1:0]  exc;
  } ent_t;

  typedef struct {
    logic [1:0]  v;
    logic [31:0] pc0, pc1;
    int          take;
    logic        fl, keep;
    int          e_cnt;
    logic [1:0]  e_ov;
    logic [31:0] e_pc0, e_pc1;
    logic        e_rdy;
  } vec_t;

  ent_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hDEAD_BEEF;
  endfunction

  function automatic logic [1:0] exc_of(input logic [31:0] pc);
    return pc[3:2];
  endfunction

  // Drive one cycle of inputs, advance the model by the queue rules, land on the next negedge.
  task automatic drive(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1,
                       input logic [31:0] i0, input logic [31:0] i1,
                       input logic [1:0] e0, input logic [1:0] e1,
                       input int take, input logic fl, input logic keep);
    int   sz, avail, pop;
    bit   rdy;
    ent_t pushes[$];
    in_valid   = v;
    in_pc      = {p1, p0};
    in_inst    = {i1, i0};
    in_exc     = {e1, e0};
    out_take   = 2'(take);
    flush      = fl;
    flush_keep = keep;
    sz    = q.size();
    rdy   = (DEPTH - sz) >= LANES;
    avail = (sz < LANES) ? sz : LANES;
    pop   = (take < avail) ? take : avail;
    if (rdy && v[0]) pushes.push_back('{pc: p0, inst: i0, exc: e0});
    if (rdy && v[1]) pushes.push_back('{pc: p1, inst: i1, exc: e1});
    repeat (pop) void'(q.pop_front());
    if (fl) begin
`ifdef IQ_DELAY_SLOT_EN
      if (keep && q.size() > 0) begin
        ent_t k = q[0];
        q.delete();
        q.push_back(k);
      end else if (keep && pushes.size() > 0) begin
        q.delete();
        q.push_back(pushes[0]);
      end else begin
        q.delete();
      end
`else
      q.delete();
`endif
    end else begin
      foreach (pushes[k]) q.push_back(pushes[k]);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = '0; in_pc = '0; in_inst = '0; in_exc = '0;
    out_take = '0; flush = 1'b0; flush_keep = 1'b0;
  endtask

  task automatic model_check(input string tag);
    logic [1:0]  ev;
    logic [63:0] epc, einst;
    logic [3:0]  eexc;
    ev = '0; epc = '0; einst = '0; eexc = '0;
    for (int i = 0; i < 2; i++) begin
      if (i < q.size()) begin
        ev[i] = 1'b1;
        epc[32*i +: 32]   = q[i].pc;
        einst[32*i +: 32] = q[i].inst;
        eexc[2*i +: 2]    = q[i].exc;
      end
    end
    chk({tag, "_count"}, 64'(count), 64'(q.size()));
    chk({tag, "_ready"}, 64'(in_ready), 64'((DEPTH - q.size()) >= LANES));
    chk({tag, "_valid"}, 64'(out_valid), 64'(ev));
    chk({tag, "_pc"}, out_pc, epc);
    chk({tag, "_inst"}, out_inst, einst);
    chk({tag, "_exc"}, 64'(out_exc), 64'(eexc));
  endtask

  vec_t tbl[17];

  initial begin
    logic [31:0] exp_seq, next_pc;
    logic [63:0] einst;
    logic [3:0]  eexc;

    tbl[0]  = '{2'b11, 32'h100, 32'h104, 0, 0, 0, 2, 2'b11, 32'h100, 32'h104, 1};
    tbl[1]  = '{2'b11, 32'h108, 32'h10C, 0, 0, 0, 4, 2'b11, 32'h100, 32'h104, 1};
    tbl[2]  = '{2'b11, 32'h110, 32'h114, 0, 0, 0, 6, 2'b11, 32'h100, 32'h104, 1};
    tbl[3]  = '{2'b11, 32'h118, 32'h11C, 0, 0, 0, 8, 2'b11, 32'h100, 32'h104, 0};
    tbl[4]  = '{2'b11, 32'h120, 32'h124, 1, 0, 0, 7, 2'b11, 32'h104, 32'h108, 0};
    tbl[5]  = '{2'b00, 32'h0,   32'h0,   2, 0, 0, 5, 2'b11, 32'h10C, 32'h110, 1};
    tbl[6]  = '{2'b00, 32'h0,   32'h0,   3, 0, 0, 3, 2'b11, 32'h114, 32'h118, 1};
    tbl[7]  = '{2'b11, 32'h200, 32'h204, 2, 0, 0, 3, 2'b11, 32'h11C, 32'h200, 1};
    tbl[8]  = '{2'b00, 32'h0,   32'h0,   1, 1, 0, 0, 2'b00, 32'h0,   32'h0,   1};
    tbl[9]  = '{2'b11, 32'h200, 32'h204, 0, 0, 0, 2, 2'b11, 32'h200, 32'h204, 1};
    tbl[10] = '{2'b11, 32'h208, 32'h20C, 0, 0, 0, 4, 2'b11, 32'h200, 32'h204, 1};
`ifdef IQ_DELAY_SLOT_EN
    tbl[11] = '{2'b00, 32'h0,   32'h0,   1, 1, 1, 1, 2'b01, 32'h204, 32'h0,   1};
`else
    tbl[11] = '{2'b00, 32'h0,   32'h0,   1, 1, 1, 0, 2'b00, 32'h0,   32'h0,   1};
`endif
    tbl[12] = '{2'b00, 32'h0,   32'h0,   0, 1, 0, 0, 2'b00, 32'h0,   32'h0,   1};
`ifdef IQ_DELAY_SLOT_EN
    tbl[13] = '{2'b11, 32'h300, 32'h304, 0, 1, 1, 1, 2'b01, 32'h300, 32'h0,   1};
`else
    tbl[13] = '{2'b11, 32'h300, 32'h304, 0, 1, 1, 0, 2'b00, 32'h0,   32'h0,   1};
`endif
    tbl[14] = '{2'b00, 32'h0,   32'h0,   0, 1, 0, 0, 2'b00, 32'h0,   32'h0,   1};
    tbl[15] = '{2'b01, 32'h400, 32'h0,   0, 0, 0, 1, 2'b01, 32'h400, 32'h0,   1};
    tbl[16] = '{2'b00, 32'h0,   32'h0,   2, 0, 0, 0, 2'b00, 32'h0,   32'h0,   1};

    reset = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_ready", 64'(in_ready), 64'd1);
    chk("reset_pc", out_pc, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    foreach (tbl[r]) begin
      drive(tbl[r].v, tbl[r].pc0, tbl[r].pc1, inst_of(tbl[r].pc0), inst_of(tbl[r].pc1),
            exc_of(tbl[r].pc0), exc_of(tbl[r].pc1), tbl[r].take, tbl[r].fl, tbl[r].keep);
      einst = '0; eexc = '0;
      if (tbl[r].e_ov[0]) begin einst[31:0]  = inst_of(tbl[r].e_pc0); eexc[1:0] = exc_of(tbl[r].e_pc0); end
      if (tbl[r].e_ov[1]) begin einst[63:32] = inst_of(tbl[r].e_pc1); eexc[3:2] = exc_of(tbl[r].e_pc1); end
      chk($sformatf("vec%0d_count", r), 64'(count), 64'(tbl[r].e_cnt));
      chk($sformatf("vec%0d_valid", r), 64'(out_valid), 64'(tbl[r].e_ov));
      chk($sformatf("vec%0d_ready", r), 64'(in_ready), 64'(tbl[r].e_rdy));
      chk($sformatf("vec%0d_pc", r), out_pc, {tbl[r].e_pc1, tbl[r].e_pc0});
      chk($sformatf("vec%0d_inst", r), out_inst, einst);
      chk($sformatf("vec%0d_exc", r), 64'(out_exc), 64'(eexc));
    end
    idle();

    // Reset pulsed between edges must clear outputs without a clock.
    drive(2'b11, 32'h500, 32'h504, 32'h1, 32'h2, 2'd1, 2'd2, 0, 0, 0);
    idle();
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_count", 64'(count), 64'd0);
    chk("async_valid", 64'(out_valid), 64'd0);
    chk("async_ready", 64'(in_ready), 64'd1);
    chk("async_pc", out_pc, 64'd0);
    q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Streaming push 2 / take 1 through many pointer wraps.
    exp_seq = 32'h0;
    next_pc = 32'h0;
    for (int c = 0; c < 40; c++) begin
      bit rdy;
      rdy = (DEPTH - q.size()) >= LANES;
      if (q.size() > 0) begin
        chk("stream_pc", 64'(out_pc[31:0]), 64'(exp_seq));
        exp_seq = exp_seq + 32'd4;
      end
      drive(2'b11, next_pc, next_pc + 32'd4, inst_of(next_pc), inst_of(next_pc + 32'd4),
            exc_of(next_pc), exc_of(next_pc + 32'd4), 1, 0, 0);
      if (rdy) next_pc = next_pc + 32'd8;
      model_check("stream");
    end

    // Random traffic against the queue model.
    for (int c = 0; c < 400; c++) begin
      int   n;
      logic [1:0] v;
      n = int'($urandom_range(0, 2));
      v = {n == 2, n >= 1};
      drive(v, $urandom, $urandom, $urandom, $urandom, 2'($urandom), 2'($urandom),
            int'($urandom_range(0, 3)), $urandom_range(0, 15) == 0, 1'($urandom));
      model_check("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
